// File: rtl/bbqm_pkg.sv
// Shared definitions for the bank-queue manager: wait-time FSM states,
// width derivations and the wait-time saturation limit.
package bbqm_pkg;

   // Wait-time computation sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } wt_state_t;

   // Bits needed to hold an occupancy of 0..max_p
   function automatic int pcount_w(input int max_p);
      return $clog2(max_p + 1);
   endfunction

   // Bits needed for the largest dividend SERVICE_T*(MAX_P + Tmax - 1)
   function automatic int num_w(input int service_t, input int max_p, input int tcount_w);
      return $clog2(service_t * (max_p + (1 << tcount_w) - 1) + 1);
   endfunction

   // Largest value representable on a w-bit wait-time output
   function automatic longint sat_limit(input int w);
      return (longint'(1) << w) - 1;
   endfunction

endpackage

// File: rtl/bbqm_divider.sv
// Restoring unsigned divider, one quotient bit per clock. start loads the
// operands, abort drops an in-flight division, done pulses for one cycle
// when the quotient is final.
module bbqm_divider #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         abort,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CW = $clog2(W);
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   logic [W-1:0]  rem;
   logic [W-1:0]  den;
   logic [CW-1:0] cnt;
   logic [W:0]    shifted;
   logic [W-1:0]  diff;
   logic          ge;

   // Trial subtraction of the divisor from the shifted partial remainder
   always_comb begin
      shifted = {rem, quotient[W-1]};
      ge      = (shifted >= {1'b0, den});
      diff    = shifted[W-1:0] - den;
   end

   // Iteration state: the quotient register doubles as the dividend shifter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         rem      <= '0;
         den      <= '0;
         quotient <= '0;
         cnt      <= '0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            busy <= 1'b0;
         end else if (start) begin
            busy     <= 1'b1;
            rem      <= '0;
            den      <= divisor;
            quotient <= dividend;
            cnt      <= '0;
         end else if (busy) begin
            rem      <= ge ? diff : shifted[W-1:0];
            quotient <= {quotient[W-2:0], ge};
            cnt      <= cnt + CW'(1);
            if (cnt == LAST) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/bbqm_gen2.sv
// Bank-queue manager: counts arrivals/departures from two push-buttons,
// raises empty/full/alarm flags and estimates the wait time
// floor(SERVICE_T*(Pcount+T-1)/T) with a sequential divider.
// Optional macro BBQM_INPUT_SYNC_EN adds a 2-flop synchroniser on Up/Down.
module bbqm_gen2
   import bbqm_pkg::*;
#(
   parameter int MAX_P     = 7,
   parameter int TCOUNT_W  = 2,
   parameter int SERVICE_T = 3,
   parameter int WTIME_W   = 8,
   localparam int PCOUNT_W = pcount_w(MAX_P)
) (
   input  logic                CLK,
   input  logic                reset,
   input  logic                Up,
   input  logic                Down,
   input  logic [TCOUNT_W-1:0] Tcount,
   output logic [PCOUNT_W-1:0] Pcount,
   output logic [WTIME_W-1:0]  Wtime,
   output logic                Wtime_valid,
   output logic                Empty_Flag,
   output logic                Full_Flag,
   output logic                Alarm_Flag
);

   localparam int NUM_W  = num_w(SERVICE_T, MAX_P, TCOUNT_W);
   localparam int ITER_W = $clog2(NUM_W);
   localparam logic [ITER_W-1:0]   ITER_LAST = ITER_W'(NUM_W - 1);
   localparam logic [PCOUNT_W-1:0] MAX_PC    = PCOUNT_W'(MAX_P);
   localparam longint              WT_MAX    = sat_limit(WTIME_W);

   // ---------------- button front end ----------------
   logic [1:0] btn;
   logic [1:0] btn_s;
   logic [1:0] btn_edge;
   logic       primed;

   assign btn = {Down, Up};

`ifdef BBQM_INPUT_SYNC_EN
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] prime;

   // Two-flop synchroniser; prime marks when sync2 carries real samples
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
         prime <= '0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
         prime <= {prime[0], 1'b1};
      end
   end

   assign btn_s  = sync2;
   assign primed = prime[1];
`else
   assign btn_s  = btn;
   assign primed = 1'b1;
`endif

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_btn
         logic prev;
         logic block;

         // Rising-edge detect; block suppresses a level already high at reset
         // release until the button has been seen low once
         always_ff @(posedge CLK or posedge reset) begin
            if (reset) begin
               prev  <= 1'b0;
               block <= 1'b1;
            end else begin
               prev <= btn_s[gi];
               if (primed && !btn_s[gi])
                  block <= 1'b0;
            end
         end

         assign btn_edge[gi] = btn_s[gi] & ~prev & ~block;
      end
   endgenerate

   // ---------------- occupancy and flags ----------------
   logic                up_ev;
   logic                dn_ev;
   logic [PCOUNT_W-1:0] pcount_next;
   logic                alarm_next;

   assign up_ev = btn_edge[0];
   assign dn_ev = btn_edge[1];

   // Next occupancy; simultaneous edges cancel and leave the alarm alone
   always_comb begin
      pcount_next = Pcount;
      alarm_next  = Alarm_Flag;
      if (up_ev && !dn_ev) begin
         if (Pcount < MAX_PC)
            pcount_next = Pcount + PCOUNT_W'(1);
         else
            alarm_next = 1'b1;
      end else if (dn_ev && !up_ev) begin
         if (Pcount != '0) begin
            pcount_next = Pcount - PCOUNT_W'(1);
            alarm_next  = 1'b0;
         end
      end
   end

   // Occupancy register with flags kept coincident with it
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         Pcount     <= '0;
         Empty_Flag <= 1'b1;
         Full_Flag  <= 1'b0;
         Alarm_Flag <= 1'b0;
      end else begin
         Pcount     <= pcount_next;
         Empty_Flag <= (pcount_next == '0);
         Full_Flag  <= (pcount_next == MAX_PC);
         Alarm_Flag <= alarm_next;
      end
   end

   // ---------------- wait-time computation ----------------
   logic [TCOUNT_W-1:0] tcount_reg;
   logic                change;
   wt_state_t           state;
   logic [ITER_W-1:0]   iter;
   logic                div_start;
   logic                div_abort;
   logic                div_busy;
   logic                div_done;
   logic [NUM_W-1:0]    dividend;
   logic [NUM_W-1:0]    divisor;
   logic [NUM_W-1:0]    quotient;
   logic [WTIME_W-1:0]  wt_sat;

   // Registered teller count; a new value restarts the estimate
   always_ff @(posedge CLK or posedge reset) begin
      if (reset)
         tcount_reg <= '0;
      else
         tcount_reg <= Tcount;
   end

   assign change    = (pcount_next != Pcount) || (Tcount != tcount_reg);
   assign div_start = (state == LOAD);
   assign div_abort = change && (state != IDLE);

   // Operands from the already-updated registers; T-1 is tcount_reg itself
   always_comb begin
      dividend = NUM_W'(SERVICE_T * (int'(Pcount) + int'(tcount_reg)));
      divisor  = NUM_W'(int'(tcount_reg) + 1);
   end

   // Clamp the quotient to the output range
   always_comb begin
      if (longint'(quotient) > WT_MAX)
         wt_sat = WTIME_W'(WT_MAX);
      else
         wt_sat = WTIME_W'(quotient);
   end

   bbqm_divider #(.W(NUM_W)) u_div (
      .clk      (CLK),
      .rst      (reset),
      .start    (div_start),
      .abort    (div_abort),
      .dividend (dividend),
      .divisor  (divisor),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (quotient)
   );

   // Sequencer: any input change (re)starts at LOAD; Wtime only moves in DONE
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         iter        <= '0;
         Wtime       <= '0;
         Wtime_valid <= 1'b1;
      end else if (change) begin
         state       <= LOAD;
         iter        <= '0;
         Wtime_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: ;
            LOAD: begin
               state <= DIV;
               iter  <= '0;
            end
            DIV: begin
               if (!div_busy)
                  state <= LOAD;
               else if (iter == ITER_LAST)
                  state <= DONE;
               else
                  iter <= iter + ITER_W'(1);
            end
            DONE: begin
               if (div_done) begin
                  state       <= IDLE;
                  Wtime       <= (Pcount == '0) ? '0 : wt_sat;
                  Wtime_valid <= 1'b1;
               end else begin
                  state <= LOAD;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bbqm_gen2.sv
// Directed bench for bbqm_gen2 with default parameters. Expected occupancy
// and wait times come from a small queue model and are queued as stimulus
// is driven, then popped when the DUT output is due.
module tb_bbqm_gen2;

   localparam int NUM_W = 5;
`ifdef BBQM_INPUT_SYNC_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   logic       CLK = 1'b0;
   logic       reset = 1'b0;
   logic       Up = 1'b0;
   logic       Down = 1'b0;
   logic [1:0] Tcount = 2'd0;
   logic [2:0] Pcount;
   logic [7:0] Wtime;
   logic       Wtime_valid;
   logic       Empty_Flag;
   logic       Full_Flag;
   logic       Alarm_Flag;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      int p;
      int e;
      int f;
      int a;
   } occ_t;

   occ_t occ_q[$];
   int   wt_q[$];
   int   m_p = 0;
   int   m_a = 0;

   always #5 CLK = ~CLK;

   bbqm_gen2 dut (
      .CLK         (CLK),
      .reset       (reset),
      .Up          (Up),
      .Down        (Down),
      .Tcount      (Tcount),
      .Pcount      (Pcount),
      .Wtime       (Wtime),
      .Wtime_valid (Wtime_valid),
      .Empty_Flag  (Empty_Flag),
      .Full_Flag   (Full_Flag),
      .Alarm_Flag  (Alarm_Flag)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_wt(input int p, input int t);
      int q;
      if (p == 0) return 0;
      q = (3 * (p + t)) / (t + 1);
      return (q > 255) ? 255 : q;
   endfunction

   // One press of Up and/or Down, then compare occupancy and flags
   task automatic pulse(input logic u, input logic d, input string tag);
      occ_t x;
      int   old_p;
      old_p = m_p;
      if (u && !d) begin
         if (m_p < 7) m_p++;
         else m_a = 1;
      end else if (d && !u) begin
         if (m_p > 0) begin
            m_p--;
            m_a = 0;
         end
      end
      occ_q.push_back('{m_p, int'(m_p == 0), int'(m_p == 7), m_a});
      @(negedge CLK);
      Up = u;
      Down = d;
      @(negedge CLK);
      Up = 1'b0;
      Down = 1'b0;
      check({tag, "_early"}, 32'(Pcount), (LAT == 0) ? m_p : old_p);
      repeat (LAT) @(negedge CLK);
      x = occ_q.pop_front();
      $display("step %s: Pcount=%0d E=%0d F=%0d A=%0d", tag, Pcount, Empty_Flag, Full_Flag, Alarm_Flag);
      check({tag, "_pcount"}, 32'(Pcount), x.p);
      check({tag, "_empty"}, 32'(Empty_Flag), x.e);
      check({tag, "_full"}, 32'(Full_Flag), x.f);
      check({tag, "_alarm"}, 32'(Alarm_Flag), x.a);
   endtask

   // Bounded wait for Wtime_valid, then compare latency and value
   task automatic wait_valid(input string tag, input int exp_lat);
      int n;
      int exp_w;
      n = 0;
      while (Wtime_valid !== 1'b1 && n < 60) begin
         @(negedge CLK);
         n++;
      end
      exp_w = wt_q.pop_front();
      $display("wtime %s: Wtime=%0d valid=%0d after %0d cycles", tag, Wtime, Wtime_valid, n);
      if (exp_lat >= 0) check({tag, "_lat"}, n, exp_lat);
      check({tag, "_valid"}, 32'(Wtime_valid), 1);
      check({tag, "_wtime"}, 32'(Wtime), exp_w);
   endtask

   initial begin
      // asynchronous reset, checked before any clock edge
      #1 reset = 1'b1;
      #1;
      check("rst_pcount", 32'(Pcount), 0);
      check("rst_wtime", 32'(Wtime), 0);
      check("rst_valid", 32'(Wtime_valid), 1);
      check("rst_empty", 32'(Empty_Flag), 1);
      check("rst_full", 32'(Full_Flag), 0);
      check("rst_alarm", 32'(Alarm_Flag), 0);
      repeat (3) @(negedge CLK);
      reset = 1'b0;

      // three arrivals with one teller
      pulse(1'b1, 1'b0, "up1");
      pulse(1'b1, 1'b0, "up2");
      pulse(1'b1, 1'b0, "up3");
      wt_q.push_back(model_wt(3, 0));
      check("up3_vlow", 32'(Wtime_valid), 0);
      wait_valid("p3", NUM_W + 2);

      // fill to MAX_P, then one rejected arrival
      for (int i = 4; i <= 7; i++) pulse(1'b1, 1'b0, "fill");
      pulse(1'b1, 1'b0, "up8");
      wt_q.push_back(model_wt(7, 0));
      wait_valid("p7", -1);
      pulse(1'b0, 1'b1, "dn6");
      wt_q.push_back(model_wt(6, 0));
      check("dn6_vlow", 32'(Wtime_valid), 0);
      wait_valid("p6", NUM_W + 2);

      // teller count change with five queued
      pulse(1'b0, 1'b1, "dn5");
      @(negedge CLK);
      Tcount = 2'd3;
      @(negedge CLK);
      check("t3_vlow", 32'(Wtime_valid), 0);
      check("t3_hold", 32'(Wtime), model_wt(6, 0));
      wt_q.push_back(model_wt(5, 3));
      wait_valid("t3", NUM_W + 2);

      // teller change while dividing restarts the estimate
      @(negedge CLK);
      Tcount = 2'd0;
      repeat (3) @(negedge CLK);
      Tcount = 2'd1;
      @(negedge CLK);
      check("t1_vlow", 32'(Wtime_valid), 0);
      wt_q.push_back(model_wt(5, 1));
      wait_valid("t1", NUM_W + 2);

      // simultaneous edges, drain, departure at empty
      pulse(1'b0, 1'b1, "dn4");
      pulse(1'b1, 1'b1, "both4");
      for (int i = 0; i < 4; i++) pulse(1'b0, 1'b1, "drain");
      wt_q.push_back(model_wt(0, 1));
      wait_valid("p0", -1);
      pulse(1'b0, 1'b1, "dn_at0");
      check("dn0_valid", 32'(Wtime_valid), 1);

      // reset mid-computation with Up held through release
      pulse(1'b1, 1'b0, "up_r");
      @(negedge CLK);
      Up = 1'b1;
      Tcount = 2'd0;
      reset = 1'b1;
      @(negedge CLK);
      check("rst2_pcount", 32'(Pcount), 0);
      check("rst2_wtime", 32'(Wtime), 0);
      check("rst2_valid", 32'(Wtime_valid), 1);
      reset = 1'b0;
      m_p = 0;
      m_a = 0;
      repeat (10) @(negedge CLK);
      check("held_pcount", 32'(Pcount), 0);
      check("held_valid", 32'(Wtime_valid), 1);
      check("held_wtime", 32'(Wtime), 0);
      Up = 1'b0;
      pulse(1'b1, 1'b0, "up_again");
      wt_q.push_back(model_wt(1, 0));
      wait_valid("p1", NUM_W + 2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
